// File: rtl/sigmoid_arbiter.sv
// sigmoid_arbiter: round-robin arbiter that shares one combinational Q4.12
// sigmoid unit among N_REQ requesters through a two-stage pipeline
// (S1 operand register, S2 result register) with a backpressured,
// id-tagged response channel.
module sigmoid_arbiter #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [16*N_REQ-1:0]     req_data,
    output logic [N_REQ-1:0]        req_ready,
    output logic                    rsp_valid,
    output logic [ID_W-1:0]         rsp_id,
    output logic signed [15:0]      rsp_data,
    input  logic                    rsp_ready,
    output logic                    busy
);

    localparam logic [12:0] ONE = 13'd4096;

    // Sigmoid sampled every 0.5 on [0, 8] in Q4.12, rounded to nearest.
    // The knot at 8.0 (and anything beyond) is pinned to exactly 1.0 so the
    // curve saturates cleanly at both ends of the Q4.12 input range.
    function automatic logic [12:0] knot(input logic [4:0] k);
        case (k)
            5'd0:    knot = 13'd2048;
            5'd1:    knot = 13'd2550;
            5'd2:    knot = 13'd2994;
            5'd3:    knot = 13'd3349;
            5'd4:    knot = 13'd3608;
            5'd5:    knot = 13'd3785;
            5'd6:    knot = 13'd3902;
            5'd7:    knot = 13'd3976;
            5'd8:    knot = 13'd4022;
            5'd9:    knot = 13'd4051;
            5'd10:   knot = 13'd4069;
            5'd11:   knot = 13'd4079;
            5'd12:   knot = 13'd4086;
            5'd13:   knot = 13'd4090;
            5'd14:   knot = 13'd4092;
            5'd15:   knot = 13'd4094;
            default: knot = ONE;
        endcase
    endfunction

    // Odd-symmetric piecewise-linear sigmoid: interpolate on |x| between
    // half-unit knots with round-half-up, then mirror as 1 - s(|x|) for x < 0.
    function automatic logic signed [15:0] sigmoid_q412(input logic signed [15:0] x);
        logic [15:0] mag;
        logic [12:0] a;
        logic [12:0] b;
        logic [12:0] diff;
        logic [12:0] pos;
        logic [23:0] prod;
        mag  = x[15] ? (16'd0 - x) : x;
        a    = knot(mag[15:11]);
        b    = knot(mag[15:11] + 5'd1);
        diff = b - a;
        prod = 24'(diff) * 24'(mag[10:0]) + 24'd1024;
        pos  = a + prod[23:11];
        sigmoid_q412 = {3'b000, (x[15] ? (ONE - pos) : pos)};
    endfunction

    logic                   r_v1;
    logic signed [15:0]     r_x1;
    logic [ID_W-1:0]        r_id1;
    logic                   r_v2;
    logic signed [15:0]     r_y2;
    logic [ID_W-1:0]        r_id2;
    logic [ID_W-1:0]        r_ptr;

    logic                   w_adv2;
    logic                   w_s1_free;
    logic                   w_found;
    logic [ID_W-1:0]        w_win;
    logic                   w_xfer;
    logic signed [15:0]     w_sel;

    assign w_adv2    = !r_v2 || rsp_ready;
    assign w_s1_free = !r_v1 || w_adv2;
    assign w_xfer    = w_found && w_s1_free;
    assign w_sel     = req_data[int'(w_win)*16 +: 16];

    // Rotating-priority search: first valid requester at or after the pointer
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            int idx;
            idx = int'(r_ptr) + k;
            if (idx >= N_REQ) idx = idx - N_REQ;
            if (!w_found && req_valid[idx]) begin
                w_found = 1'b1;
                w_win   = ID_W'(idx);
            end
        end
    end

    // Grant is combinational and unlocked; it only becomes a transfer when S1 can take it
    always_comb begin
        req_ready = '0;
        if (w_xfer) req_ready[w_win] = 1'b1;
    end

    // S1: capture the granted operand, or empty when S1 drains with nothing new
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v1  <= 1'b0;
            r_x1  <= '0;
            r_id1 <= '0;
            r_ptr <= '0;
        end else if (w_xfer) begin
            r_v1  <= 1'b1;
            r_x1  <= w_sel;
            r_id1 <= w_win;
            r_ptr <= (int'(w_win) == N_REQ - 1) ? '0 : w_win + 1'b1;
        end else if (w_s1_free) begin
            r_v1  <= 1'b0;
        end
    end

    // S2: take the sigmoid of S1 whenever the response slot can advance
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v2  <= 1'b0;
            r_y2  <= '0;
            r_id2 <= '0;
        end else if (w_adv2) begin
            r_v2  <= r_v1;
            r_y2  <= sigmoid_q412(r_x1);
            r_id2 <= r_id1;
        end
    end

    assign rsp_valid = r_v2;
    assign rsp_data  = r_y2;
    assign rsp_id    = r_id2;
    assign busy      = r_v1 || r_v2;

endmodule

// File: tb/tb_sigmoid_arbiter.sv
// Testbench for sigmoid_arbiter: a 4-requester instance driven by directed
// and random traffic against a queue-based reference model, plus a
// 3-requester instance for pointer wrap and grant movement.
module tb_sigmoid_arbiter;

    logic        clk = 1'b0;
    logic        rst;

    logic [3:0]  rv4;
    logic [63:0] rd4;
    logic [3:0]  rr4;
    logic        rsp_valid4;
    logic [1:0]  rid4;
    logic [15:0] rdat4;
    logic        rrdy4;
    logic        busy4;

    logic [2:0]  rv3;
    logic [47:0] rd3;
    logic [2:0]  rr3;
    logic        rsp_valid3;
    logic [1:0]  rid3;
    logic [15:0] rdat3;
    logic        rrdy3;
    logic        busy3;

    int n_cmp = 0;
    int n_err = 0;

    // reference model state for the 4-requester instance
    int q_id[$];
    int q_dat[$];
    int q_cyc[$];
    int m_ptr;
    int cyc;
    int last_acc;

    always #5 clk = ~clk;

    sigmoid_arbiter #(.N_REQ(4), .ID_W(2)) u_dut4 (
        .clk(clk), .rst(rst),
        .req_valid(rv4), .req_data(rd4), .req_ready(rr4),
        .rsp_valid(rsp_valid4), .rsp_id(rid4), .rsp_data(rdat4),
        .rsp_ready(rrdy4), .busy(busy4)
    );

    sigmoid_arbiter #(.N_REQ(3), .ID_W(2)) u_dut3 (
        .clk(clk), .rst(rst),
        .req_valid(rv3), .req_data(rd3), .req_ready(rr3),
        .rsp_valid(rsp_valid3), .rsp_id(rid3), .rsp_data(rdat3),
        .rsp_ready(rrdy3), .busy(busy3)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // true sigmoid at x = k/2, scaled to Q4.12 and rounded; pinned to 1.0 from 8 on
    function automatic real knot_ref(input int k);
        if (k >= 16) return 4096.0;
        return $floor(4096.0 / (1.0 + $exp(-real'(k) / 2.0)) + 0.5);
    endfunction

    // odd-symmetric linear interpolation between half-unit knots
    function automatic int ref_sig(input logic signed [15:0] x);
        real m, f, a, b, y;
        int  k;
        m = (x < 0) ? -real'(x) : real'(x);
        m = m / 4096.0;
        k = int'($floor(m * 2.0));
        f = m * 2.0 - real'(k);
        a = knot_ref(k);
        b = knot_ref(k + 1);
        y = $floor(a + (b - a) * f + 0.5);
        if (x < 0) y = 4096.0 - y;
        return int'(y);
    endfunction

    // one clock of the 4-requester instance: check against the model, then advance it
    task automatic tick4();
        bit         found, hs, can, vis;
        int         win;
        logic [3:0] exp_rdy;
        #1;
        vis = (q_id.size() > 0) && (q_cyc[0] + 2 <= cyc);
        hs  = vis && rrdy4;
        can = (q_id.size() < 2) || hs;
        found = 1'b0;
        win   = 0;
        for (int k = 0; k < 4; k++) begin
            int i;
            i = (m_ptr + k) % 4;
            if (!found && rv4[i]) begin
                found = 1'b1;
                win   = i;
            end
        end
        exp_rdy = (found && can) ? 4'(1 << win) : 4'b0000;
        check("req_ready", rr4, exp_rdy);
        check("rsp_valid", rsp_valid4, vis);
        check("busy", busy4, q_id.size() > 0);
        if (vis) begin
            check("rsp_id", rid4, q_id[0]);
            check("rsp_data", rdat4, q_dat[0]);
        end
        last_acc = (found && can) ? win : -1;
        @(posedge clk);
        if (hs) begin
            void'(q_id.pop_front());
            void'(q_dat.pop_front());
            void'(q_cyc.pop_front());
        end
        if (found && can) begin
            q_id.push_back(win);
            q_dat.push_back(ref_sig(rd4[16*win +: 16]));
            q_cyc.push_back(cyc);
            m_ptr = (win + 1) % 4;
        end
        cyc++;
        #1;
    endtask

    task automatic model_reset();
        q_id.delete();
        q_dat.delete();
        q_cyc.delete();
        m_ptr = 0;
    endtask

    initial begin
        rst = 1'b1;
        rv4 = '0; rd4 = '0; rrdy4 = 1'b0;
        rv3 = '0; rd3 = '0; rrdy3 = 1'b0;
        model_reset();
        cyc = 0;
        last_acc = -1;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("por_rsp_valid", rsp_valid4, 1'b0);
        check("por_busy", busy4, 1'b0);
        check("por_rsp_data", rdat4, 16'h0000);
        rst = 1'b0;

        // reset mid-operation: fill both stages, then reset between edges
        rv4 = 4'b0001; rd4[15:0] = 16'h0000; rrdy4 = 1'b0;
        tick4();
        tick4();
        tick4();
        rst = 1'b1;
        #1;
        check("rst_rsp_valid", rsp_valid4, 1'b0);
        check("rst_busy", busy4, 1'b0);
        check("rst_rsp_data", rdat4, 16'h0000);
        check("rst_rsp_id", rid4, 2'd0);
        model_reset();
        rv4 = 4'b0000;
        @(posedge clk);
        #1;
        rst = 1'b0;
        rv4 = 4'b1111;
        rd4 = {16'h8000, 16'h7FFF, 16'h0800, 16'h0000};
        rrdy4 = 1'b1;
        #1;
        check("rst_first_grant", rr4, 4'b0001);
        tick4();
        rv4 = 4'b0000;
        repeat (3) tick4();

        // single request from requester 1
        rv4 = 4'b0010; rd4[31:16] = 16'h0800;
        tick4();
        rv4 = 4'b0000;
        tick4();
        check("single_valid", rsp_valid4, 1'b1);
        check("single_id", rid4, 2'd1);
        check("single_data", rdat4, 16'h09F6);
        repeat (2) tick4();

        // round-robin streaming, then backpressure for 5 cycles, then release
        rv4 = 4'b1111;
        rd4 = {16'h8000, 16'h7FFF, 16'h0800, 16'h0000};
        rrdy4 = 1'b1;
        repeat (10) tick4();
        rrdy4 = 1'b0;
        repeat (5) tick4();
        rrdy4 = 1'b1;
        repeat (6) tick4();
        rv4 = 4'b0000;
        repeat (3) tick4();

        // random traffic honouring the hold-until-accepted obligation
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < 4; i++) begin
                if (!rv4[i] && $urandom_range(0, 2) == 0) begin
                    rv4[i] = 1'b1;
                    rd4[16*i +: 16] = 16'($urandom);
                end
            end
            rrdy4 = ($urandom_range(0, 3) != 0);
            tick4();
            if (last_acc >= 0) rv4[last_acc] = 1'b0;
        end
        rv4 = 4'b0000;
        rrdy4 = 1'b1;
        repeat (4) tick4();

        // three requesters: pointer wrap and grant move while stalled
        rv3 = 3'b001; rd3[15:0] = 16'h0800; rrdy3 = 1'b0;
        #1;
        check("n3_a_ready", rr3, 3'b001);
        @(posedge clk); #1;
        rv3 = 3'b010; rd3[31:16] = 16'h0000;
        #1;
        check("n3_b_ready", rr3, 3'b010);
        check("n3_b_rsp_valid", rsp_valid3, 1'b0);
        @(posedge clk); #1;
        rv3 = 3'b001; rd3[15:0] = 16'h8000;
        #1;
        check("n3_stall_ready", rr3, 3'b000);
        check("n3_stall_valid", rsp_valid3, 1'b1);
        check("n3_stall_id", rid3, 2'd0);
        check("n3_stall_data", rdat3, 16'h09F6);
        check("n3_stall_busy", busy3, 1'b1);
        @(posedge clk); #1;
        rv3 = 3'b101; rd3[47:32] = 16'h7FFF;
        #1;
        check("n3_stall2_ready", rr3, 3'b000);
        check("n3_stall2_data", rdat3, 16'h09F6);
        @(posedge clk); #1;
        rrdy3 = 1'b1;
        #1;
        check("n3_moved_grant", rr3, 3'b100);
        @(posedge clk); #1;
        rv3 = 3'b001;
        #1;
        check("n3_wrap_grant", rr3, 3'b001);
        check("n3_rsp1_id", rid3, 2'd1);
        check("n3_rsp1_data", rdat3, 16'h0800);
        @(posedge clk); #1;
        rv3 = 3'b000;
        #1;
        check("n3_rsp2_id", rid3, 2'd2);
        check("n3_rsp2_data", rdat3, 16'h1000);
        check("n3_idle_ready", rr3, 3'b000);
        @(posedge clk); #1;
        check("n3_rsp3_valid", rsp_valid3, 1'b1);
        check("n3_rsp3_id", rid3, 2'd0);
        check("n3_rsp3_data", rdat3, 16'h0000);
        @(posedge clk); #1;
        check("n3_drained_valid", rsp_valid3, 1'b0);
        check("n3_drained_busy", busy3, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
